uart_tx_8051_multimode: RTL and testbench
=========================================

// Module: uart_tx_8051_multimode
// PURPOSE
//  Parametrised 8051-style serial transmitter covering all four SCON modes: 0 (sync shift), 1 (async 8-bit),
//  2 (9-bit fixed rate), 3 (9-bit variable rate). Successor of the mode-1-only transmitter.
//  Adds: mode select, TB8 ninth bit, full-length stop bit, TI flag, and a 1-deep holding buffer
//  for back-to-back frames. Sits between the SBUF/SCON register file and the TXD/RXD pins;
//  tick sources come from the timer/baud block.
// PARAMETERS
//  DATA_W  8  data bits per frame (5..9), sent LSB first
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous reset, active-high
//  mode      in   2       00 shift, 01 8-bit UART, 10 9-bit fixed, 11 9-bit variable; sampled on frame load
//  tx_valid  in   1       write request: tx_data/tx_tb8 valid
//  tx_ready  out  1       holding buffer empty; write accepted when tx_valid && tx_ready
//  tx_data   in   DATA_W  frame payload
//  tx_tb8    in   1       ninth bit, modes 2/3 only
//  tick_baud in   1       1-clk bit tick, modes 1/3
//  tick_fix  in   1       1-clk bit tick, mode 2
//  tick_shift in  1       1-clk half-bit tick, mode 0
//  ti_clr    in   1       software clear of ti
//  tx        out  1       async serial line, idle 1
//  sdat      out  1       mode-0 data, idle 1
//  sclk      out  1       mode-0 shift clock, idle 1
//  tx_busy   out  1       frame in progress
//  ti        out  1       sticky transmit-done flag
// BEHAVIOUR
//  - Reset (sync): tx=1, sdat=1, sclk=1, tx_busy=0, tx_ready=1, ti=0; shift reg, hold buf, counters cleared.
//    Reset mid-frame aborts: line back to 1 at next edge, queued word discarded.
//  - Accepted write goes to hold buf (tx_ready=0). If idle, hold buf moves to shift reg next clk:
//    tx_busy=1, tx_ready=1, mode/tb8 latched. Mode input ignored until next load.
//  - Active tick = latched-mode source; other ticks ignored. States: IDLE, WAIT, SHIFT, DONE.
//    WAIT -> SHIFT on first active tick.
//  - Mode 1 frame: start 0, DATA_W bits, stop 1 (DATA_W+2 bits).
//    Modes 2/3 frame: start, DATA_W bits, tb8, stop (DATA_W+3 bits).
//    Tick k drives bit k. Tick (N+1) ends the frame, so the stop bit is held a full bit period.
//  - Mode 0 frame: DATA_W bits on sdat, 2 ticks/bit. Odd tick: sclk=0, sdat=bit. Even tick: sclk=1.
//    Frame ends on tick 2*DATA_W. tx stays 1.
//  - Frame end (single clk): tx_busy=0 and ti=1. If hold buf full at the same tick, next frame loads
//    in that tick, and mode 1/2/3 drive its start bit on that tick (no idle gap).
//    tx_busy stays 1 for a back-to-back frame.
//  - ti is set at every frame end and cleared by ti_clr. If set and clear coincide, set wins.
//  - Write in the same clk as hold buf drains: accepted, no loss.
//  - Bit counter: $clog2(2*DATA_W+1) bits, no wrap within a frame.
// STRUCTURE
//  - Shared package uart8051_pkg: mode encodings MODE_SHIFT/MODE_8B/MODE_9B_FIX/MODE_9B_VAR,
//    tx state enum, frame-length function.
//  - Sub-module uart_tx_hold_buf: 1-deep valid/ready holding register.
//    Frame builder and tick mux stay in the top.
// TESTING (DATA_W=8)
//  1. Mode 1, 0xA5, tick_baud every 16 clk -> tx on ticks 1..10 = 0,1,0,1,0,0,1,0,1,1.
//     busy falls and ti=1 on tick 11.
//  2. Mode 3, 0x3C, tb8=1 -> tx = 0,0,0,1,1,1,1,0,0,1,1; done on tick 12.
//     tick_fix pulses during the frame have no effect.
//  3. Mode 1, writes 0x55 then 0x0F with 0x0F arriving mid-frame -> tx_ready=0 until the first frame ends.
//     Stop bit of 0x55 is followed directly by the start bit of 0x0F; ti set twice.
//  4. Mode 0, 0x81 -> sdat bits 1,0,0,0,0,0,0,1, each sclk 0->1; done after 16 tick_shift; tx stays 1.
//  5. rst asserted during bit 4 of mode 2 with hold buf full -> next clk tx=1, busy=0, ready=1, ti=0.
//     No further output.
//  6. ti_clr in the same clk as frame end -> ti=1.
//     Mode switched 01->11 mid-frame -> current frame stays 10 bits.

Source files
------------

// File: rtl/uart8051_pkg.sv
// Shared definitions for the 8051-style serial transmitter: mode encodings, FSM states,
// and frame-length helper in units of active ticks.
package uart8051_pkg;

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_8B     = 2'b01;
    localparam logic [1:0] MODE_9B_FIX = 2'b10;
    localparam logic [1:0] MODE_9B_VAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } tx_state_e;

    // Ticks from first bit to frame end: async modes add one tick so the stop bit is a full period.
    function automatic int frame_ticks(input logic [1:0] m, input int dw);
        case (m)
            MODE_SHIFT: return 2 * dw;
            MODE_8B:    return dw + 3;
            default:    return dw + 4;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_hold_buf.sv
// One-entry holding register between the SBUF write port and the frame shifter.
// Latency 1 clk write-to-visible; in_rdy is low while the entry is occupied.
module uart_tx_hold_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_pop,
    output logic [W-1:0] out_dat
);

    logic         full_q;
    logic [W-1:0] dat_q;

    assign in_rdy  = !full_q;
    assign out_vld = full_q;
    assign out_dat = dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else if (in_vld && in_rdy) begin
            full_q <= 1'b1;
            dat_q  <= in_dat;
        end else if (out_pop) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_8051_multimode.sv
// 8051 SCON-mode serial transmitter (sync shift, 8-bit async, 9-bit fixed/variable rate).
// Bits change on the clk of each active tick; a queued word loads on the ending tick with no gap.
module uart_tx_8051_multimode
    import uart8051_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_tb8,
    input  logic              tick_baud,
    input  logic              tick_fix,
    input  logic              tick_shift,
    input  logic              ti_clr,
    output logic              tx,
    output logic              sdat,
    output logic              sclk,
    output logic              tx_busy,
    output logic              ti
);

    localparam int FW = DATA_W + 3;
    localparam int CW = $clog2(2 * DATA_W + 1);

    tx_state_e       state_q, state_d;
    logic [1:0]      mode_q;
    logic [FW-1:0]   sh_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   last_cnt;
    logic            tx_q, sdat_q, sclk_q, ti_q;

    logic            hb_vld;
    logic [DATA_W:0] hb_dat;
    logic [FW-1:0]   frame_w;
    logic            act_tick, step, end_tick, load, load_start;

    // Shift register is consumed from bit 0; vacated positions fill with the idle level.
    function automatic logic [FW-1:0] build_frame(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic t);
        if (m == MODE_SHIFT)   return {3'b111, d};
        else if (m == MODE_8B) return {2'b11, d, 1'b0};
        else                   return {1'b1, t, d, 1'b0};
    endfunction

    uart_tx_hold_buf #(.W(DATA_W + 1)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (tx_valid),
        .in_rdy  (tx_ready),
        .in_dat  ({tx_tb8, tx_data}),
        .out_vld (hb_vld),
        .out_pop (load),
        .out_dat (hb_dat)
    );

    always_comb begin
        act_tick = 1'b0;
        case (mode_q)
            MODE_SHIFT:  act_tick = tick_shift;
            MODE_9B_FIX: act_tick = tick_fix;
            default:     act_tick = tick_baud;
        endcase
    end

    assign last_cnt   = CW'(frame_ticks(mode_q, DATA_W) - 1);
    assign step       = act_tick && (state_q == ST_WAIT || state_q == ST_SHIFT);
    assign end_tick   = act_tick && (state_q == ST_SHIFT) && (cnt_q == last_cnt);
    assign load       = hb_vld && (state_q == ST_IDLE || state_q == ST_DONE || end_tick);
    assign load_start = load && end_tick && (mode != MODE_SHIFT);
    assign frame_w    = build_frame(mode, hb_dat[DATA_W-1:0], hb_dat[DATA_W]);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = load ? ST_WAIT : ST_IDLE;
            ST_WAIT:          if (act_tick) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (end_tick) begin
                    if (!load)          state_d = ST_DONE;
                    else if (load_start) state_d = ST_SHIFT;
                    else                state_d = ST_WAIT;
                end
            end
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_8B;
            sh_q   <= '1;
            cnt_q  <= '0;
            tx_q   <= 1'b1;
            sdat_q <= 1'b1;
            sclk_q <= 1'b1;
            ti_q   <= 1'b0;
        end else begin
            if (end_tick)    ti_q <= 1'b1;
            else if (ti_clr) ti_q <= 1'b0;

            if (state_q == ST_DONE) sdat_q <= 1'b1;

            if (load) begin
                mode_q <= mode;
                sh_q   <= frame_w;
                cnt_q  <= '0;
                if (end_tick) sclk_q <= 1'b1;
                // Back-to-back async frame: this tick doubles as tick 1 of the new frame.
                if (load_start) begin
                    tx_q  <= 1'b0;
                    sh_q  <= {1'b1, frame_w[FW-1:1]};
                    cnt_q <= CW'(1);
                end
            end else if (step) begin
                cnt_q <= cnt_q + CW'(1);
                if (mode_q == MODE_SHIFT) begin
                    if (!cnt_q[0]) begin
                        sclk_q <= 1'b0;
                        sdat_q <= sh_q[0];
                        sh_q   <= {1'b1, sh_q[FW-1:1]};
                    end else begin
                        sclk_q <= 1'b1;
                    end
                end else begin
                    tx_q <= sh_q[0];
                    sh_q <= {1'b1, sh_q[FW-1:1]};
                end
            end
        end
    end

    always_comb begin
        tx_busy = (state_q == ST_WAIT) || (state_q == ST_SHIFT);
        tx      = tx_q;
        sdat    = sdat_q;
        sclk    = sclk_q;
        ti      = ti_q;
    end

endmodule

// File: tb/tb_uart_tx_8051_multimode.sv
// Scoreboard bench: writes push expected frames, a monitor checks each active tick.
module tb_uart_tx_8051_multimode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b01;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       tx_tb8 = 1'b0;
    logic       tick_baud = 1'b0;
    logic       tick_fix = 1'b0;
    logic       tick_shift = 1'b0;
    logic       ti_clr = 1'b0;
    logic       tx, sdat, sclk, tx_busy, ti;

    localparam int T_BAUD  = 0;
    localparam int T_FIX   = 1;
    localparam int T_SHIFT = 2;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] bits;
        int          n;
    } frame_t;

    frame_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_8051_multimode #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_tb8     (tx_tb8),
        .tick_baud  (tick_baud),
        .tick_fix   (tick_fix),
        .tick_shift (tick_shift),
        .ti_clr     (ti_clr),
        .tx         (tx),
        .sdat       (sdat),
        .sclk       (sclk),
        .tx_busy    (tx_busy),
        .ti         (ti)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic tick_sel(input logic [1:0] m, input logic b, input logic f, input logic s);
        case (m)
            2'b00:   return s;
            2'b10:   return f;
            default: return b;
        endcase
    endfunction

    // bits: LSB is the value expected after tick 1 (sdat bit order for mode 0).
    task automatic write(input logic [1:0] m, input logic [7:0] d, input logic t,
                         input logic [15:0] bits, input int n);
        frame_t f;
        int guard;
        @(negedge clk);
        mode = m; tx_data = d; tx_tb8 = t; tx_valid = 1'b1;
        guard = 0;
        while (!tx_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!tx_ready) begin
            check1("write_timeout", 1'b0, 1'b1);
        end else begin
            @(posedge clk);
            f.mode = m; f.bits = bits; f.n = n;
            exp_q.push_back(f);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic ticks(input int n, input int which, input int gap, input bit clr_last);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) @(negedge clk);
            case (which)
                T_BAUD:  tick_baud = 1'b1;
                T_FIX:   tick_fix = 1'b1;
                default: tick_shift = 1'b1;
            endcase
            if (clr_last && i == n - 1) ti_clr = 1'b1;
            @(negedge clk);
            case (which)
                T_BAUD:  tick_baud = 1'b0;
                T_FIX:   tick_fix = 1'b0;
                default: tick_shift = 1'b0;
            endcase
            if (clr_last && i == n - 1) ti_clr = 1'b0;
        end
    endtask

    // Monitor: counts active ticks of the head frame and checks the line after each one.
    initial begin : mon
        frame_t cur;
        bit     active;
        int     idx;
        logic   b, f, s, r;
        active = 0;
        idx = 0;
        forever begin
            @(posedge clk);
            b = tick_baud; f = tick_fix; s = tick_shift; r = rst;
            #1;
            if (r) begin
                exp_q.delete();
                active = 0;
                continue;
            end
            if (!active) begin
                if (exp_q.size() == 0) continue;
                cur = exp_q[0];
                idx = 0;
            end
            if (!tick_sel(cur.mode, b, f, s)) continue;
            active = 1;
            idx++;
            if (cur.mode == 2'b00) begin
                check1("m0_tx_idle", tx, 1'b1);
                if (idx[0]) begin
                    check1("m0_sclk_low", sclk, 1'b0);
                    check1("m0_sdat", sdat, cur.bits[(idx - 1) / 2]);
                end else begin
                    check1("m0_sclk_high", sclk, 1'b1);
                end
                if (idx < 2 * cur.n) begin
                    check1("m0_busy", tx_busy, 1'b1);
                    continue;
                end
            end else if (idx <= cur.n) begin
                check1("tx_bit", tx, cur.bits[idx - 1]);
                check1("busy_in_frame", tx_busy, 1'b1);
                continue;
            end
            check1("ti_at_end", ti, 1'b1);
            void'(exp_q.pop_front());
            active = 0;
            if (exp_q.size() > 0) begin
                cur = exp_q[0];
                active = 1;
                idx = 0;
                if (cur.mode != 2'b00) begin
                    idx = 1;
                    check1("b2b_start_bit", tx, cur.bits[0]);
                    check1("b2b_busy", tx_busy, 1'b1);
                end
            end else begin
                check1("busy_end", tx_busy, 1'b0);
            end
        end
    end

    initial begin : stim
        bit seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check1("rst_tx", tx, 1'b1);
        check1("rst_sdat", sdat, 1'b1);
        check1("rst_sclk", sclk, 1'b1);
        check1("rst_busy", tx_busy, 1'b0);
        check1("rst_ready", tx_ready, 1'b1);
        check1("rst_ti", ti, 1'b0);

        // Mode 1, 0xA5: 0,1,0,1,0,0,1,0,1,1
        write(2'b01, 8'hA5, 1'b0, 16'h034A, 10);
        ticks(11, T_BAUD, 16, 1'b0);
        repeat (5) @(negedge clk);

        // Mode 3, 0x3C tb8=1: 0,0,0,1,1,1,1,0,0,1,1 with stray tick_fix pulses
        write(2'b11, 8'h3C, 1'b1, 16'h0678, 11);
        fork
            ticks(12, T_BAUD, 16, 1'b0);
            ticks(20, T_FIX, 9, 1'b0);
        join
        repeat (5) @(negedge clk);

        // Mode 1 back-to-back: 0x55 then 0x0F queued mid-frame
        write(2'b01, 8'h55, 1'b0, 16'h02AA, 10);
        fork
            ticks(21, T_BAUD, 16, 1'b0);
            begin
                repeat (40) @(negedge clk);
                write(2'b01, 8'h0F, 1'b0, 16'h021E, 10);
                seen = 0;
                repeat (120) begin
                    @(negedge clk);
                    if (tx_ready) seen = 1;
                end
                check1("t3_ready_held_low", seen, 1'b0);
                repeat (30) @(negedge clk);
                check1("t3_ready_after_drain", tx_ready, 1'b1);
                ti_clr = 1'b1;
                @(negedge clk);
                ti_clr = 1'b0;
                check1("t3_ti_cleared", ti, 1'b0);
            end
        join
        repeat (5) @(negedge clk);

        // Mode 0, 0x81: sdat 1,0,0,0,0,0,0,1
        write(2'b00, 8'h81, 1'b0, 16'h0081, 8);
        ticks(16, T_SHIFT, 4, 1'b0);
        repeat (4) @(negedge clk);
        check1("t4_sdat_idle", sdat, 1'b1);
        check1("t4_ti", ti, 1'b1);

        // Mode 2 with hold buffer full, reset after bit 4
        write(2'b10, 8'hC3, 1'b0, 16'h0586, 11);
        write(2'b10, 8'h11, 1'b1, 16'h0622, 11);
        ticks(4, T_FIX, 8, 1'b0);
        check1("t5_buf_full", tx_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check1("t5_tx", tx, 1'b1);
        check1("t5_busy", tx_busy, 1'b0);
        check1("t5_ready", tx_ready, 1'b1);
        check1("t5_ti", ti, 1'b0);
        repeat (6) begin
            ticks(1, T_FIX, 8, 1'b0);
            check1("t5_quiet_tx", tx, 1'b1);
            check1("t5_quiet_busy", tx_busy, 1'b0);
        end

        // Mode 1 frame, mode input switched to 3 mid-frame, ti_clr on the end tick
        write(2'b01, 8'h96, 1'b0, 16'h032C, 10);
        fork
            ticks(11, T_BAUD, 16, 1'b1);
            begin
                repeat (30) @(negedge clk);
                mode = 2'b11;
            end
        join
        check1("t6_ti_set_wins", ti, 1'b1);
        ti_clr = 1'b1;
        @(negedge clk);
        ti_clr = 1'b0;
        check1("t6_ti_clear", ti, 1'b0);

        repeat (20) @(negedge clk);
        checkn("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
